stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//  Upstream stage of the 4-digit 7-segment display: turns two raw pushbuttons into a start/pause/clear stopwatch.
//  Produces a 4-digit BCD seconds count, 0000..9999, for the segment scan/decode stage.
//  Replaces the free-running seconds counter: display logic gets ready BCD digits, with no /10 or %10 arithmetic.
// PARAMETERS
//  TICK_DIV         49999999  clock cycles per count step minus 1 (50 MHz -> 1 s)
//  DEBOUNCE_CYCLES  999999    cycles a synced input must differ from the stable state, minus 1 (~20 ms)
// PORTS
//  clk_i          in   1   system clock, 50 MHz
//  rst_n_i        in   1   synchronous reset, active-low
//  btn_start_n_i  in   1   raw start/pause button, asynchronous, active-low (0 = pressed)
//  btn_clear_n_i  in   1   raw clear button, asynchronous, active-low
//  bcd_o          out  16  [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units; each digit 0..9
//  running_o      out  1   1 while in RUN
//  tick_o         out  1   1-cycle pulse in the cycle bcd_o steps
//  wrap_o         out  1   1-cycle pulse in the cycle bcd_o steps 9999 -> 0000
// BEHAVIOUR
//  Reset (rst_n_i=0 at an edge)
//   - bcd_o=0, running_o=0, tick_o=0, wrap_o=0, state=IDLE, prescaler=0.
//   - Synchronizer flops and debounce stable state = 1 (released); debounce counters = 0.
//   - Reset mid-operation aborts everything. A button held through reset is seen as one press after debounce.
//  Input path, per button, identical
//   - 2-flop synchronizer s1 -> s2.
//   - Debounce: while s2 != stable, cnt increments each cycle. When cnt==DEBOUNCE_CYCLES and s2 still differs: stable<=s2, cnt<=0.
//   - Any cycle with s2==stable sets cnt<=0, so glitches shorter than DEBOUNCE_CYCLES+1 cycles are ignored.
//   - Press event: registered 1-cycle pulse on stable 1->0. Release generates no event.
//   - Latency: raw edge before clock edge 0 -> FSM/running_o change at edge 5+DEBOUNCE_CYCLES.
//  FSM (states IDLE, RUN, PAUSE; all outputs registered)
//   - IDLE : start -> RUN, prescaler=0. clear -> stay in IDLE.
//   - RUN  : start -> PAUSE. clear -> IDLE, bcd_o=0, prescaler=0.
//   - PAUSE: start -> RUN, prescaler keeps its value so partial seconds are kept. clear -> IDLE, bcd_o=0, prescaler=0.
//   - Start and clear events in the same cycle: clear wins.
//   - running_o = (state==RUN).
//  Prescaler/count
//   - Prescaler counts only in RUN; range 0..TICK_DIV.
//   - In RUN with prescaler==TICK_DIV: prescaler<=0, bcd_o increments, tick_o=1 in the same registered update.
//     First step comes TICK_DIV+1 cycles after entering RUN from IDLE.
//   - BCD increment is a ripple cascade: a digit at 9 becomes 0 and carries; a digit never holds 10..15.
//   - 9999 + 1 -> 0000 with wrap_o=1 and tick_o=1; stays in RUN.
//   - Clear event in the same cycle as a step: clear wins. bcd_o=0, no tick_o, no wrap_o.
//   - Pause event in the same cycle as a step: the step completes (bcd_o increments, tick_o=1), then state=PAUSE.
//  tick_o and wrap_o are 0 in every other cycle.
// TESTING (bench params: TICK_DIV=4, DEBOUNCE_CYCLES=3)
//  1. Reset, then hold both buttons high for 50 cycles -> bcd_o=0x0000, running_o=0, no tick_o.
//  2. Start pulse of 3 cycles (glitch) -> ignored, running_o stays 0.
//     Hold start low 10 cycles -> running_o=1 exactly 8 edges after the fall.
//  3. Run 5 s -> tick_o every 5 cycles, bcd_o = 0x0001..0x0005. Units 9 -> 0x0010. 0x0099 -> 0x0100.
//  4. Preload to 0x9998, run -> 0x9999, then 0x0000 with wrap_o=1 and tick_o=1 in the same cycle; running_o stays 1.
//  5. Pause 2 cycles after a step, hold 100 cycles, resume -> bcd_o frozen while paused;
//     next step 3 cycles after the resume event.
//  6. Start and clear debounced in the same cycle while in RUN at 0x0042 -> IDLE, bcd_o=0x0000.
//     Assert rst_n_i=0 mid-RUN -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and BCD/status outputs of the stopwatch controller, bundled as one port.
interface stopwatch_ctrl_if;
    logic        btn_start_n_i;
    logic        btn_clear_n_i;
    logic [15:0] bcd_o;
    logic        running_o;
    logic        tick_o;
    logic        wrap_o;

    // Drives the raw buttons and observes the count (board glue or bench).
    modport master (
        output btn_start_n_i, btn_clear_n_i,
        input  bcd_o, running_o, tick_o, wrap_o
    );

    // The stopwatch controller itself.
    modport slave (
        input  btn_start_n_i, btn_clear_n_i,
        output bcd_o, running_o, tick_o, wrap_o
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Start/pause/clear stopwatch: two raw active-low buttons in, a 4-digit BCD
// seconds count out, ready for the 7-segment scan/decode stage.
module stopwatch_ctrl #(
    parameter int TICK_DIV        = 49999999,
    parameter int DEBOUNCE_CYCLES = 999999
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    stopwatch_ctrl_if.slave  bus
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int PS_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    logic [1:0] raw;
    logic [1:0] press;

    // Index 0 is start, index 1 is clear; both go through the same input path.
    assign raw = {bus.btn_clear_n_i, bus.btn_start_n_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            stable_reg;
            logic            stable_d_reg;
            logic            stable_dd_reg;
            logic            press_reg;
            logic [DB_W-1:0] cnt_reg;

            // Synchronize, debounce, then flag a press on the retimed stable 1->0 edge.
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    sync1_reg     <= 1'b1;
                    sync2_reg     <= 1'b1;
                    stable_reg    <= 1'b1;
                    stable_d_reg  <= 1'b1;
                    stable_dd_reg <= 1'b1;
                    press_reg     <= 1'b0;
                    cnt_reg       <= '0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg != stable_reg) begin
                        if (cnt_reg == DB_W'(DEBOUNCE_CYCLES)) begin
                            stable_reg <= sync2_reg;
                            cnt_reg    <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + DB_W'(1);
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                    stable_d_reg  <= stable_reg;
                    stable_dd_reg <= stable_d_reg;
                    press_reg     <= stable_dd_reg & ~stable_d_reg;
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    logic            start_evt;
    logic            clear_evt;
    state_t          state_reg;
    logic [PS_W-1:0] presc_reg;
    logic [15:0]     bcd_reg;
    logic [15:0]     bcd_next;
    logic            all_nine;
    logic            running_reg;
    logic            tick_reg;
    logic            wrap_reg;

    assign start_evt = press[0];
    assign clear_evt = press[1];

    // Ripple BCD increment: a 9 rolls to 0 and carries, so no digit ever holds 10..15.
    always_comb begin
        bcd_next = bcd_reg;
        all_nine = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (all_nine) begin
                if (bcd_reg[4*i +: 4] == 4'd9) begin
                    bcd_next[4*i +: 4] = 4'd0;
                end else begin
                    bcd_next[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd1;
                    all_nine = 1'b0;
                end
            end
        end
    end

    // Control FSM with prescaler and count; clear beats start, a pause lets a same-cycle step finish.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg   <= IDLE;
            presc_reg   <= '0;
            bcd_reg     <= '0;
            running_reg <= 1'b0;
            tick_reg    <= 1'b0;
            wrap_reg    <= 1'b0;
        end else begin
            tick_reg <= 1'b0;
            wrap_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!clear_evt && start_evt) begin
                        state_reg   <= RUN;
                        running_reg <= 1'b1;
                        presc_reg   <= '0;
                    end
                end
                RUN: begin
                    if (clear_evt) begin
                        state_reg   <= IDLE;
                        running_reg <= 1'b0;
                        presc_reg   <= '0;
                        bcd_reg     <= '0;
                    end else begin
                        if (presc_reg == PS_W'(TICK_DIV)) begin
                            presc_reg <= '0;
                            bcd_reg   <= bcd_next;
                            tick_reg  <= 1'b1;
                            wrap_reg  <= all_nine;
                        end else begin
                            presc_reg <= presc_reg + PS_W'(1);
                        end
                        if (start_evt) begin
                            state_reg   <= PAUSE;
                            running_reg <= 1'b0;
                        end
                    end
                end
                PAUSE: begin
                    if (clear_evt) begin
                        state_reg <= IDLE;
                        presc_reg <= '0;
                        bcd_reg   <= '0;
                    end else if (start_evt) begin
                        state_reg   <= RUN;
                        running_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    running_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bcd_o     = bcd_reg;
    assign bus.running_o = running_reg;
    assign bus.tick_o    = tick_reg;
    assign bus.wrap_o    = wrap_reg;

endmodule
